// File: rtl/dense_layer_par.sv
// Fully connected layer computing P neurons in parallel per weight-memory word,
// with bias, arithmetic requantisation shift, saturation and optional ReLU.
module dense_layer_par #(
  parameter int IN_BITS    = 16,
  parameter int W_BITS     = 8,
  parameter int OUT_BITS   = 16,
  parameter int ACC_BITS   = 32,
  parameter int N          = 64,
  parameter int M          = 32,
  parameter int P          = 4,
  parameter int MEM_LAT    = 2,
  parameter int SHIFT      = 0,
  parameter int RELU_ON    = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N*IN_BITS-1:0]    in_vec,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [P*W_BITS-1:0]     mem_dout,
  output logic                    busy,
  output logic                    done,
  output logic [M*OUT_BITS-1:0]   out_vec
);

  localparam int G  = M / P;
  localparam int IW = $clog2(N + 1);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(N);
  localparam logic [GW-1:0] LAST_GRP   = GW'(G - 1);
  localparam logic [LW-1:0] LAST_DRAIN = LW'(MEM_LAT - 1);

  localparam logic signed [ACC_BITS-1:0] OMAX =
    {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] OMIN =
    {{(ACC_BITS-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  if (M % P != 0) begin : g_bad_lanes
    $error("dense_layer_par: M must be a multiple of P");
  end
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("dense_layer_par: MEM_LAT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t                      state, state_next;
  logic [GW-1:0]               grp;
  logic [IW-1:0]               idx;
  logic [LW-1:0]               dcnt;
  logic [N*IN_BITS-1:0]        in_lat;
  logic [MEM_LAT-1:0]          vpipe;
  logic [IW-1:0]               ipipe    [MEM_LAT];
  logic signed [ACC_BITS-1:0]  acc      [P];
  logic signed [ACC_BITS-1:0]  acc_next [P];
  logic signed [ACC_BITS-1:0]  prod     [P];
  logic signed [ACC_BITS-1:0]  shifted  [P];
  logic signed [ACC_BITS-1:0]  clamped  [P];
  logic signed [W_BITS-1:0]    w_lane   [P];
  logic signed [IN_BITS-1:0]   in_sel;
  logic [OUT_BITS-1:0]         sat      [P];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == LAST_DRAIN) state_next = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        state_next = (grp == LAST_GRP) ? DONE : ISSUE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The index travelling with each returning word selects activation or bias.
  always_comb begin
    in_sel = in_lat[int'(ipipe[MEM_LAT-1])*IN_BITS +: IN_BITS];
    for (int k = 0; k < P; k++) begin
      w_lane[k] = mem_dout[k*W_BITS +: W_BITS];
      prod[k]   = ACC_BITS'(in_sel) * ACC_BITS'(w_lane[k]);
      if (ipipe[MEM_LAT-1] == LAST_IDX) acc_next[k] = acc[k] + ACC_BITS'(w_lane[k]);
      else                              acc_next[k] = acc[k] + prod[k];
      shifted[k] = acc[k] >>> SHIFT;
      if (shifted[k] > OMAX)      clamped[k] = OMAX;
      else if (shifted[k] < OMIN) clamped[k] = OMIN;
      else                        clamped[k] = shifted[k];
      if (RELU_ON != 0 && clamped[k] < 0) clamped[k] = '0;
      sat[k] = clamped[k][OUT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp      <= '0;
      idx      <= '0;
      dcnt     <= '0;
      in_lat   <= '0;
      mem_addr <= '0;
      vpipe    <= '0;
      out_vec  <= '0;
      for (int s = 0; s < MEM_LAT; s++) ipipe[s] <= '0;
      for (int k = 0; k < P; k++) acc[k] <= '0;
    end else begin
      vpipe[0] <= (state == ISSUE);
      ipipe[0] <= idx;
      for (int s = 1; s < MEM_LAT; s++) begin
        vpipe[s] <= vpipe[s-1];
        ipipe[s] <= ipipe[s-1];
      end
      if (vpipe[MEM_LAT-1]) begin
        for (int k = 0; k < P; k++) acc[k] <= acc_next[k];
      end
      case (state)
        IDLE: if (start) begin
          in_lat   <= in_vec;
          grp      <= '0;
          idx      <= '0;
          mem_addr <= '0;
          for (int k = 0; k < P; k++) acc[k] <= '0;
        end
        ISSUE: begin
          if (idx == LAST_IDX) begin
            idx  <= '0;
            dcnt <= '0;
          end else begin
            idx      <= idx + IW'(1);
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: dcnt <= dcnt + LW'(1);
        // Groups are contiguous, so the next base is one past the bias word.
        WRITE: begin
          for (int k = 0; k < P; k++) begin
            out_vec[(int'(grp)*P + k)*OUT_BITS +: OUT_BITS] <= sat[k];
            acc[k] <= '0;
          end
          if (grp != LAST_GRP) begin
            grp      <= grp + GW'(1);
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_par.sv
// Scoreboard bench: two small layer configurations share one weight memory image
// and are exercised in turn; expected outputs come from a behavioural model.
module tb_dense_layer_par;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int P  = 2;
  localparam int IB = 16;
  localparam int WB = 8;
  localparam int OB = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n, start, sel;
  logic [N*IB-1:0] in_vec;
  logic [AW-1:0]   addr_a, addr_b;
  logic [P*WB-1:0] dout_a, dout_b;
  logic            busy_a, busy_b, done_a, done_b;
  logic [M*OB-1:0] out_a, out_b;

  logic [P*WB-1:0] mem [16];
  logic [P*WB-1:0] pa  [2];
  logic [P*WB-1:0] pb  [3];

  int in_m [N];
  int w_m  [M][N];
  int b_m  [M];
  logic [M*OB-1:0] sb_q [$];
  int vectors = 0;
  int errors  = 0;

  wire start_a = start & ~sel;
  wire start_b = start & sel;
  wire busy_s  = sel ? busy_b : busy_a;
  wire done_s  = sel ? done_b : done_a;

  always #5 clk = ~clk;

  dense_layer_par #(.IN_BITS(IB), .W_BITS(WB), .OUT_BITS(OB), .ACC_BITS(32), .N(N), .M(M),
    .P(P), .MEM_LAT(2), .SHIFT(0), .RELU_ON(1), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_vec(in_vec), .mem_addr(addr_a),
    .mem_dout(dout_a), .busy(busy_a), .done(done_a), .out_vec(out_a));

  dense_layer_par #(.IN_BITS(IB), .W_BITS(WB), .OUT_BITS(OB), .ACC_BITS(32), .N(N), .M(M),
    .P(P), .MEM_LAT(3), .SHIFT(2), .RELU_ON(0), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_vec(in_vec), .mem_addr(addr_b),
    .mem_dout(dout_b), .busy(busy_b), .done(done_b), .out_vec(out_b));

  always @(posedge clk) begin
    pa[0] <= mem[addr_a];
    pa[1] <= pa[0];
    pb[0] <= mem[addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign dout_a = pa[1];
  assign dout_b = pb[2];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a || done_b) begin
      check_output("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check_output(done_b ? "out_b" : "out_a", done_b ? out_b : out_a, sb_q.pop_front());
    end
  end

  function automatic logic [M*OB-1:0] expect_out(input int shift, input bit relu);
    logic [M*OB-1:0] res;
    int acc, r;
    int omax = (1 <<< (OB-1)) - 1;
    int omin = -(1 <<< (OB-1));
    res = '0;
    for (int j = 0; j < M; j++) begin
      acc = b_m[j];
      for (int i = 0; i < N; i++) acc += in_m[i] * w_m[j][i];
      r = acc >>> shift;
      if (r > omax) r = omax;
      else if (r < omin) r = omin;
      if (relu && r < 0) r = 0;
      res[j*OB +: OB] = OB'(r);
    end
    return res;
  endfunction

  task automatic load_mem();
    for (int a = 0; a < 16; a++) mem[a] = '0;
    for (int g = 0; g < M/P; g++)
      for (int k = 0; k < P; k++) begin
        for (int i = 0; i < N; i++) mem[g*(N+1)+i][k*WB +: WB] = WB'(w_m[g*P+k][i]);
        mem[g*(N+1)+N][k*WB +: WB] = WB'(b_m[g*P+k]);
      end
  endtask

  task automatic set_in();
    for (int i = 0; i < N; i++) in_vec[i*IB +: IB] = IB'(in_m[i]);
  endtask

  task automatic fill(input int inv, input int wv, input int b0, input int b1, input int b2, input int b3);
    for (int i = 0; i < N; i++) in_m[i] = inv + i * (inv == 1 ? 1 : 0);
    for (int j = 0; j < M; j++) for (int i = 0; i < N; i++) w_m[j][i] = wv;
    b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
    load_mem();
  endtask

  task automatic rand_in();
    for (int i = 0; i < N; i++) in_m[i] = int'($urandom_range(0, 600)) - 300;
  endtask

  task automatic rand_case();
    rand_in();
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) w_m[j][i] = int'($urandom_range(0, 255)) - 128;
      b_m[j] = int'($urandom_range(0, 255)) - 128;
    end
    load_mem();
  endtask

  task automatic apply_stimulus(input int lat, input int shift, input bit relu);
    int done_at, busy_bad;
    set_in();
    sb_q.push_back(expect_out(shift, relu));
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    done_at  = -1;
    busy_bad = 0;
    for (int k = 1; k <= lat + 10; k++) begin
      if (busy_s !== (k < lat)) busy_bad++;
      if (done_s === 1'b1) begin
        done_at = k;
        break;
      end
      @(posedge clk); #1;
    end
    check_output("done_cycle", done_at, lat);
    check_output("busy_span", busy_bad, 0);
    if (done_at < 0) sb_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int addr_bad, ndone, d1, d2;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; in_vec = '0;
    for (int a = 0; a < 16; a++) mem[a] = '0;
    repeat (3) @(posedge clk); #1;
    check_output("rst_out_a", out_a, 0);
    check_output("rst_ctl_a", {busy_a, done_a, addr_a}, 0);
    check_output("rst_out_b", out_b, 0);
    check_output("rst_ctl_b", {busy_b, done_b, addr_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Instance A: OUT_BITS=8, SHIFT=0, ReLU, MEM_LAT=2 -> done at cycle 17.
    fill(1, 1, 0, -20, 5, 0);
    apply_stimulus(17, 0, 1);
    fill(100, 127, 0, 0, 0, 0);
    apply_stimulus(17, 0, 1);
    repeat (3) begin
      rand_case();
      apply_stimulus(17, 0, 1);
    end

    // A second start mid-run must be ignored and not disturb the address stream.
    rand_case();
    set_in();
    sb_q.push_back(expect_out(0, 1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr_bad = 0; ndone = 0; d1 = -1;
    for (int k = 1; k <= 25; k++) begin
      start = (k == 5);
      if (k <= 5 && addr_a !== AW'(k - 1)) addr_bad++;
      if (k >= 9 && k <= 13 && addr_a !== AW'(k - 4)) addr_bad++;
      if (done_a === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = k;
      end
      @(posedge clk); #1;
    end
    check_output("addr_seq", addr_bad, 0);
    check_output("done_count", ndone, 1);
    check_output("repulse_done", d1, 17);

    // Reset in cycle 8 aborts the run; a fresh run must then complete normally.
    set_in();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("abort_ctl", {busy_a, done_a, addr_a}, 0);
    check_output("abort_out", out_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(17, 0, 1);

    // start held high: second run follows after one IDLE cycle, with its own inputs.
    rand_case();
    set_in();
    sb_q.push_back(expect_out(0, 1));
    start = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 3) begin
        rand_in();
        set_in();
        sb_q.push_back(expect_out(0, 1));
      end
      if (k == 19) start = 1'b0;
      if (done_a === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_output("b2b_first", d1, 17);
    check_output("b2b_gap", d2 - d1, 18);
    sb_q.delete();

    // Instance B: SHIFT=2, no ReLU, MEM_LAT=3 -> done at cycle 19.
    sel = 1'b1;
    @(posedge clk); #1;
    fill(100, -128, 0, 0, 0, 0);
    apply_stimulus(19, 2, 0);
    fill(1, 0, -5, 7, -1, 0);
    apply_stimulus(19, 2, 0);
    repeat (2) begin
      rand_case();
      apply_stimulus(19, 2, 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dense_layer_par.md
Name: dense_layer_par

Overview:
- Parametrised successor to the single-MAC dense layer: one fully connected layer with P output neurons computed in parallel per weight-memory read.
- Adds per-neuron bias, arithmetic requantisation shift, output saturation, optional ReLU, configurable memory read latency, and a start/busy/done handshake that can be re-armed.
- Sits between block-RAM weight storage and the next layer. Chained layers connect this block's done output to the next block's start input.

Parameters:
- IN_BITS, 16, signed input activation width.
- W_BITS, 8, signed weight and bias width.
- OUT_BITS, 16, signed output width after saturation.
- ACC_BITS, 32, signed accumulator width.
- N, 64, number of inputs.
- M, 32, number of outputs. M % P != 0 is an elaboration error.
- P, 4, lanes (neurons computed per memory word).
- MEM_LAT, 2, memory read latency in cycles, ≥1.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
- RELU_ON, 1, 1 = clamp negative outputs to 0.
- ADDR_WIDTH, 12, memory address width; must hold (M/P)*(N+1)-1.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset. Synchronous, active-low; clock clk.
- start, in, 1, request computation; sampled only in IDLE.
- in_vec, in, N*IN_BITS, signed inputs, element i at bits [i*IN_BITS +: IN_BITS]; latched when start is accepted.
- mem_addr, out, ADDR_WIDTH, weight memory read address.
- mem_dout, in, P*W_BITS, memory word; lane k at bits [k*W_BITS +: W_BITS]; valid MEM_LAT cycles after its address.
- busy, out, 1, high from start accepted until done.
- done, out, 1, one-cycle pulse; out_vec is valid from this cycle on.
- out_vec, out, M*OUT_BITS, signed outputs, neuron j at bits [j*OUT_BITS +: OUT_BITS]; held until the next done.

Behaviour:
- Reset values: busy=0, done=0, mem_addr=0, out_vec=0, all accumulators 0, state=IDLE. Reset mid-operation aborts, clears everything to these values, and out_vec is 0 after reset.
- Memory layout:
  - Group g (0..G-1, G=M/P) occupies addresses g*(N+1) .. g*(N+1)+N.
  - Address g*(N+1)+i (i<N) holds weights w[g*P+k][i] for lanes k=0..P-1.
  - Address g*(N+1)+N holds bias b[g*P+k].
- States:
  - IDLE: on start=1, latch in_vec, set busy, go to ISSUE with g=0. Otherwise stay.
  - ISSUE: drive the N+1 addresses of group g, one per cycle, in increasing order, for N+1 cycles.
  - DRAIN: hold for MEM_LAT cycles while returning data is accumulated.
  - WRITE: 1 cycle. Saturated results for lanes g*P..g*P+P-1 are written into out_vec. If g<G-1, increment g and go to ISSUE; else go to DONE.
  - DONE: done=1, busy=0 for 1 cycle, then IDLE.
- Accumulation:
  - Data returned for weight index i: acc_k += sext(in_i) * sext(w_k), full signed product sign-extended to ACC_BITS. Overflow wraps in ACC_BITS.
  - Bias word: acc_k += sext(b_k).
  - Accumulators clear at the start of each group.
- Requantise:
  - r = acc >>> SHIFT (arithmetic, floor).
  - Clamp r to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - If RELU_ON, negative results become 0.
- Latency: the start-accept edge is cycle 0. done is high in cycle G*(N+1+MEM_LAT+1)+1.
- start while busy is ignored (no queueing). start held high continuously re-triggers each time the block returns to IDLE.
- in_vec changes during busy have no effect.
- mem_addr holds its last value outside ISSUE.
- out_vec bits of groups not yet rewritten keep their previous-run values until the WRITE cycle of that group.

Test Plan:
- N=4, M=4, P=2, MEM_LAT=2, SHIFT=0, in=[1,2,3,4], all weights=1, biases=[0,-20,5,0] -> out=[10,0,15,10] with RELU_ON=1; done in cycle 17 (2*(5+2+1)+1); busy high cycles 1..16.
- Same setup, in=[100,100,100,100], weights=127, OUT_BITS=8 -> all outputs saturate to 127. Same with weights=-128 and RELU_ON=0 -> all outputs -128.
- SHIFT=2, RELU_ON=0, accumulated -5 -> output -2 (floor, not truncation toward zero).
- start pulsed again at cycle 5 of a run -> ignored: single done at cycle 17, and mem_addr sequence is unchanged (0..4, then 5..9).
- rst_n low at cycle 8 of a run -> next cycle busy=0, done=0, out_vec=0. A new start then produces the correct full result.
- Back-to-back: start held high -> second run's done exactly 18 cycles after the first (17 + 1 IDLE cycle). in_vec changed mid-run does not affect that run's result.
